// File: rtl/cache_mem_arbiter_pkg.sv
// Shared types for the cache/RAM arbitration slice.
package cache_mem_arbiter_pkg;

    typedef logic [31:0] word_t;

    // RAM status as reported by the RAM model
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

endpackage

// File: rtl/cache_mem_arbiter_starve_counter.sv
// Saturating counter of consecutive contested dcache grants.
module cache_mem_arbiter_starve_counter #(
    parameter int unsigned LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic limit_hit
);

    localparam int unsigned W = $clog2(LIMIT + 1);
    localparam logic [W-1:0] LIMIT_W = W'(LIMIT);

    logic [W-1:0] count_q, count_d;

    // Next count: clear wins, increment saturates at LIMIT
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q < LIMIT_W)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state is updated with <= so every flop samples pre-edge values regardless of block order.
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

    assign limit_hit = (count_q >= LIMIT_W);

endmodule

// File: rtl/cache_mem_arbiter.sv
// Arbitrates icache and dcache requests onto a single-ported RAM.
// A dcache block (two words) completes without re-arbitration; a
// starvation counter forces a waiting icache in after STARVE_LIMIT
// contested dcache grants.
module cache_mem_arbiter
    import cache_mem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter word_t       ERR_WORD     = 32'hBAD1BAD1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  word_t       iaddr,
    output logic        iwait,
    output word_t       iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  word_t       daddr,
    input  word_t       dstore,
    output logic        dwait,
    output word_t       dload,
    output logic        ramREN,
    output logic        ramWEN,
    output word_t       ramaddr,
    output word_t       ramstore,
    input  word_t       ramload,
    input  logic [1:0]  ramstate,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SERV_D = 2'd1,
        SERV_I = 2'd2
    } state_t;

    state_t    state_q, state_d;
    logic      err_q, err_d;
    logic      d_req;
    logic      starve_inc, starve_clr, starve_hit;
    ramstate_t ram_st;

    assign d_req  = dREN | dWEN;
    assign ram_st = ramstate_t'(ramstate);
    assign err    = err_q;

    cache_mem_arbiter_starve_counter #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve_counter (
        .clk       (CLK),
        .rst       (RST),
        .inc       (starve_inc),
        .clr       (starve_clr),
        .limit_hit (starve_hit)
    );

    // State and sticky error registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    // Next state, starvation bookkeeping and error capture
    always_comb begin
        state_d    = state_q;
        err_d      = err_q;
        starve_inc = 1'b0;
        starve_clr = 1'b0;
        case (state_q)
            IDLE: begin
                if (d_req && (!iREN || !starve_hit)) begin
                    state_d    = SERV_D;
                    starve_inc = iREN;
                end else if (iREN) begin
                    state_d    = SERV_I;
                    starve_clr = 1'b1;
                end
                if (!iREN) starve_clr = 1'b1;
            end
            SERV_D: begin
                if (!d_req) begin
                    state_d = IDLE;
                end else if (ram_st == ACCESS) begin
                    // First word of a block keeps the grant for the second word
                    state_d = daddr[2] ? IDLE : SERV_D;
                end else if (ram_st == ERROR) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end
            end
            SERV_I: begin
                if (!iREN || (ram_st == ACCESS)) begin
                    state_d = IDLE;
                end else if (ram_st == ERROR) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Cache handshakes and RAM strobes for the current owner
    always_comb begin
        iwait    = 1'b1;
        dwait    = 1'b1;
        iload    = '0;
        dload    = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        case (state_q)
            SERV_D: begin
                if (d_req) begin
                    ramaddr  = daddr;
                    ramstore = dstore;
                    ramWEN   = dWEN;
                    ramREN   = dREN & ~dWEN;
                    if (ram_st == ACCESS) begin
                        dwait = 1'b0;
                        dload = ramload;
                    end else if (ram_st == ERROR) begin
                        dwait = 1'b0;
                        dload = ERR_WORD;
                    end
                end
            end
            SERV_I: begin
                if (iREN) begin
                    ramaddr = iaddr;
                    ramREN  = 1'b1;
                    if (ram_st == ACCESS) begin
                        iwait = 1'b0;
                        iload = ramload;
                    end else if (ram_st == ERROR) begin
                        iwait = 1'b0;
                        iload = ERR_WORD;
                    end
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Scoreboard bench for cache_mem_arbiter: directed cache traffic against a
// small RAM model; a monitor checks every completed access in order.
module tb_cache_mem_arbiter;
    import cache_mem_arbiter_pkg::*;

    localparam int BUDGET = 200;
    localparam word_t ERR_W = 32'hBAD1BAD1;

    logic       CLK, RST;
    logic       iREN, dREN, dWEN;
    word_t      iaddr, daddr, dstore;
    logic       iwait, dwait;
    word_t      iload, dload;
    logic       ramREN, ramWEN;
    word_t      ramaddr, ramstore, ramload;
    logic [1:0] ramstate;
    logic       err;

    cache_mem_arbiter dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate),
        .err(err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ---------------- RAM model ----------------
    int   ram_busy;
    logic ram_err;
    int   ram_cnt;

    function automatic word_t rd_word(input word_t a);
        if (a == 32'h40) return 32'h12345678;
        return {a[15:0] ^ 16'h5A5A, a[15:0]};
    endfunction

    always_comb begin
        ramstate = FREE;
        ramload  = '0;
        if (ramREN || ramWEN) begin
            if (ram_cnt < ram_busy) ramstate = BUSY;
            else if (ram_err)       ramstate = ERROR;
            else                    ramstate = ACCESS;
            if (ramREN) ramload = rd_word(ramaddr);
        end
    end

    always @(posedge CLK) begin
        if ((ramREN || ramWEN) && ramstate == BUSY) ram_cnt <= ram_cnt + 1;
        else                                        ram_cnt <= 0;
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fails  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: actual %h required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic  is_d;
        word_t addr;
        logic  wen;
        word_t store;
        word_t load;
        int    gap;   // cycles since previous completion, 0 = don't care
    } exp_t;

    exp_t sb_q[$];

    function automatic exp_t mk(input logic is_d, input word_t addr, input logic wen,
                                input word_t store, input word_t load, input int gap);
        exp_t e;
        e.is_d = is_d; e.addr = addr; e.wen = wen;
        e.store = store; e.load = load; e.gap = gap;
        return e;
    endfunction

    // Monitor: every wait-low cycle must match the next expected completion
    int cyc = 0;
    int last_cyc = 0;
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            cyc++;
            if (!iwait || !dwait) begin
                check("single_owner", 32'(!iwait && !dwait), 32'd0);
                check("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    check("owner_is_d", 32'(!dwait), 32'(e.is_d));
                    check("load", e.is_d ? dload : iload, e.load);
                    check("ramaddr", ramaddr, e.addr);
                    check("ramWEN", 32'(ramWEN), 32'(e.wen));
                    check("ramREN", 32'(ramREN), 32'(!e.wen));
                    if (e.wen) check("ramstore", ramstore, e.store);
                    if (e.gap > 0) check("gap", 32'(cyc - last_cyc), 32'(e.gap));
                end
                last_cyc = cyc;
            end
        end
    end

    // ---------------- cache drivers ----------------
    task automatic i_access(input word_t addr, output int lat);
        bit done = 1'b0;
        iREN  = 1'b1;
        iaddr = addr;
        lat   = 0;
        for (int n = 1; n <= BUDGET && !done; n++) begin
            @(negedge CLK);
            if (!iwait) begin done = 1'b1; lat = n; end
        end
        if (!done) check("i_timeout", 32'(done), 32'd1);
        @(posedge CLK); #1;
    endtask

    task automatic d_access(input word_t addr, input logic wen, input word_t data, output int lat);
        bit done = 1'b0;
        dREN   = !wen;
        dWEN   = wen;
        daddr  = addr;
        dstore = data;
        lat    = 0;
        for (int n = 1; n <= BUDGET && !done; n++) begin
            @(negedge CLK);
            if (!dwait) begin done = 1'b1; lat = n; end
        end
        if (!done) check("d_timeout", 32'(done), 32'd1);
        @(posedge CLK); #1;
    endtask

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    int lat_a, lat_b;

    initial begin
        RST = 1'b1; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        iaddr = '0; daddr = '0; dstore = '0;
        ram_busy = 0; ram_err = 1'b0;
        repeat (2) @(posedge CLK);
        #1;

        // Reset values
        check("rst_iwait", 32'(iwait), 32'd1);
        check("rst_dwait", 32'(dwait), 32'd1);
        check("rst_ramREN", 32'(ramREN), 32'd0);
        check("rst_ramWEN", 32'(ramWEN), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_ramaddr", ramaddr, 32'd0);
        @(negedge CLK) RST = 1'b0;
        @(posedge CLK); #1;

        // Single icache read, zero-wait RAM
        sb_q.push_back(mk(1'b0, 32'h40, 1'b0, 32'h0, 32'h12345678, 0));
        i_access(32'h40, lat_a);
        iREN = 1'b0;
        check("i_latency", 32'(lat_a), 32'd2);

        // dcache block write against a held icache request
        sb_q.push_back(mk(1'b1, 32'h100, 1'b1, 32'hCAFE0100, 32'h0, 0));
        sb_q.push_back(mk(1'b1, 32'h104, 1'b1, 32'hCAFE0104, 32'h0, 1));
        sb_q.push_back(mk(1'b0, 32'h60, 1'b0, 32'h0, rd_word(32'h60), 2));
        fork
            begin
                d_access(32'h100, 1'b1, 32'hCAFE0100, lat_a);
                d_access(32'h104, 1'b1, 32'hCAFE0104, lat_a);
                dWEN = 1'b0;
            end
            begin
                i_access(32'h60, lat_b);
                iREN = 1'b0;
            end
        join

        // Starvation: icache wins after the 4th contested block, then the
        // cleared counter lets the dcache win again
        for (int b = 0; b < 4; b++) begin
            sb_q.push_back(mk(1'b1, 32'h400 + 32'(16 * b), 1'b0, 32'h0,
                              rd_word(32'h400 + 32'(16 * b)), (b == 0) ? 0 : 2));
            sb_q.push_back(mk(1'b1, 32'h404 + 32'(16 * b), 1'b0, 32'h0,
                              rd_word(32'h404 + 32'(16 * b)), 1));
        end
        sb_q.push_back(mk(1'b0, 32'h300, 1'b0, 32'h0, rd_word(32'h300), 2));
        sb_q.push_back(mk(1'b1, 32'h440, 1'b0, 32'h0, rd_word(32'h440), 2));
        sb_q.push_back(mk(1'b1, 32'h444, 1'b0, 32'h0, rd_word(32'h444), 1));
        sb_q.push_back(mk(1'b0, 32'h304, 1'b0, 32'h0, rd_word(32'h304), 2));
        fork
            begin
                for (int b = 0; b < 5; b++) begin
                    d_access(32'h400 + 32'(16 * b), 1'b0, 32'h0, lat_a);
                    d_access(32'h404 + 32'(16 * b), 1'b0, 32'h0, lat_a);
                end
                dREN = 1'b0;
            end
            begin
                i_access(32'h300, lat_b);
                i_access(32'h304, lat_b);
                iREN = 1'b0;
            end
        join

        // BUSY holds the access until ACCESS arrives
        ram_busy = 2;
        sb_q.push_back(mk(1'b1, 32'h10C, 1'b0, 32'h0, rd_word(32'h10C), 0));
        d_access(32'h10C, 1'b0, 32'h0, lat_a);
        dREN = 1'b0;
        check("busy_latency", 32'(lat_a), 32'd4);

        // Withdrawal while RAM is BUSY
        ram_busy = 100;
        iREN = 1'b1; iaddr = 32'h80;
        @(negedge CLK);
        @(negedge CLK);
        check("wd_ramREN_before", 32'(ramREN), 32'd1);
        check("wd_ramaddr_before", ramaddr, 32'h80);
        check("wd_iwait_before", 32'(iwait), 32'd1);
        @(posedge CLK); #1;
        iREN = 1'b0;
        @(negedge CLK);
        check("wd_ramREN", 32'(ramREN), 32'd0);
        check("wd_ramWEN", 32'(ramWEN), 32'd0);
        check("wd_iwait", 32'(iwait), 32'd1);
        @(posedge CLK); #1;
        ram_busy = 0;
        sb_q.push_back(mk(1'b0, 32'h84, 1'b0, 32'h0, rd_word(32'h84), 0));
        i_access(32'h84, lat_a);
        iREN = 1'b0;
        check("wd_idle_latency", 32'(lat_a), 32'd2);

        // RAM error during a dcache read
        ram_err = 1'b1;
        sb_q.push_back(mk(1'b1, 32'h200, 1'b0, 32'h0, ERR_W, 0));
        d_access(32'h200, 1'b0, 32'h0, lat_a);
        dREN = 1'b0;
        ram_err = 1'b0;
        check("err_set", 32'(err), 32'd1);
        check("err_latency", 32'(lat_a), 32'd2);
        sb_q.push_back(mk(1'b0, 32'h88, 1'b0, 32'h0, rd_word(32'h88), 0));
        i_access(32'h88, lat_a);
        iREN = 1'b0;
        check("err_idle_latency", 32'(lat_a), 32'd2);
        check("err_sticky", 32'(err), 32'd1);

        // Reset pulse in the middle of a dcache write
        ram_busy = 50;
        dWEN = 1'b1; daddr = 32'h500; dstore = 32'h000055AA;
        @(negedge CLK);
        @(negedge CLK);
        check("pre_rst_ramWEN", 32'(ramWEN), 32'd1);
        #2 RST = 1'b1;
        #1;
        check("mid_rst_dwait", 32'(dwait), 32'd1);
        check("mid_rst_ramWEN", 32'(ramWEN), 32'd0);
        check("mid_rst_ramREN", 32'(ramREN), 32'd0);
        check("mid_rst_err", 32'(err), 32'd0);
        check("mid_rst_ramaddr", ramaddr, 32'd0);
        dWEN = 1'b0;
        ram_busy = 0;
        iREN = 1'b1; iaddr = 32'h44;
        sb_q.push_back(mk(1'b0, 32'h44, 1'b0, 32'h0, rd_word(32'h44), 0));
        @(negedge CLK) RST = 1'b0;
        @(negedge CLK);
        check("post_rst_iwait", 32'(iwait), 32'd0);
        @(posedge CLK); #1;
        iREN = 1'b0;

        repeat (3) @(negedge CLK);
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Memory-side responder for the cache request protocol. It takes requests from the instruction cache and the data cache, drives each cache's `wait` and load data back, and forwards one request at a time to the single-ported RAM. The block sits between the two caches and the RAM model. Once the data cache starts a two-word block transfer, both words complete back to back. A starvation counter makes sure the instruction cache is still served.

## Interface
Parameters:
- `STARVE_LIMIT`, default 4: number of consecutive contested dcache grants after which a pending icache request wins.
- `ERR_WORD`, default 32'hBAD1BAD1: value returned on a RAM error.

Ports:
- `CLK`  in  1  clock; all state changes on the rising edge.
- `RST`  in  1  reset; asynchronous, active-high.
- `iREN`  in  1  icache read request.
- `iaddr`  in  32  icache word address.
- `iwait`  out  1  low for exactly the cycle the icache access completes.
- `iload`  out  32  icache read data; valid while `iwait`=0.
- `dREN`, `dWEN`  in  1 each  dcache read and write requests.
- `daddr`  in  32  dcache word address.
- `dstore`  in  32  dcache write data.
- `dwait`  out  1  low for exactly the cycle the dcache access completes.
- `dload`  out  32  dcache read data; valid while `dwait`=0.
- `ramREN`, `ramWEN`  out  1 each  RAM strobes.
- `ramaddr`  out  32  RAM address.
- `ramstore`  out  32  RAM write data.
- `ramload`  in  32  RAM read data.
- `ramstate`  in  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3.
- `err`  out  1  sticky RAM-error flag.

## Operation
The FSM has three states: IDLE, SERV_D and SERV_I.

- **Default outputs.** `iwait`=`dwait`=1, `iload`=`dload`=0, RAM strobes 0, `ramaddr`=`ramstore`=0.
- **IDLE.** Drives no RAM request and arbitrates:
  - If `dREN|dWEN` and (`!iREN` or `starve`<`STARVE_LIMIT`), go to SERV_D.
  - Otherwise, if `iREN`, go to SERV_I.
- **Starvation counter.** Saturating counter `starve`, `$clog2(STARVE_LIMIT+1)` bits.
  - Increments on an IDLE→SERV_D grant while `iREN`=1.
  - Clears on an IDLE→SERV_I grant, or on any IDLE cycle with `iREN`=0.
- **SERV_D.** Forwards `daddr`/`dstore` to `ramaddr`/`ramstore`.
  - `dWEN` has priority: if both `dWEN` and `dREN` are high, drive `ramWEN`=1, `ramREN`=0. Otherwise `ramREN`=`dREN`.
  - When `ramstate`==ACCESS: set `dwait`=0 and `dload`=`ramload` combinationally.
  - If `daddr[2]`=0 (first word of a block), stay in SERV_D. This is the block lock: the second word gets no arbitration cycle.
  - If `daddr[2]`=1, go to IDLE.
- **SERV_I.** Forwards `iaddr` with `ramREN`=1. On ACCESS: `iwait`=0, `iload`=`ramload`, then go to IDLE.
- **ERROR.** `ramstate`==ERROR in either SERV state ends the access:
  - The owning cache sees `wait`=0 with load data `ERR_WORD`.
  - `err` is set and held until reset.
  - The next state is IDLE, and the block lock is broken.
- **FREE/BUSY.** `ramstate` FREE or BUSY in a SERV state leaves the state unchanged and keeps the request asserted.
- **Withdrawal.** If the owner drops its request in a SERV state (SERV_D with `dREN|dWEN`=0, SERV_I with `iREN`=0):
  - Drive no RAM strobes that cycle.
  - Go to IDLE and do not pulse `wait` low.
- **Non-owner.** The cache that does not own the grant always sees `wait`=1.

## Timing
- **Reset.** `RST` high forces: state IDLE, `starve`=0, `err`=0, all outputs at their defaults.
  - Assertion mid-access aborts immediately, with no `wait` pulse.
  - After `RST` falls, the first rising edge performs IDLE arbitration.
- **Latency.** Request seen in IDLE at cycle 0; RAM strobe from cycle 1. With a zero-wait-state RAM (ACCESS in the first SERV cycle), `wait` falls in cycle 1.
- **Block transfer.** Second dcache word: strobe in the cycle after the first completion; `dwait` low in that cycle when the RAM reports ACCESS immediately.
- **No pipelining.** At most one outstanding RAM access.
- **Simultaneous requests in IDLE.** dcache wins while `starve`<`STARVE_LIMIT`.

## Structure
- A shared package holds the `ramstate_t` enum (FREE/BUSY/ACCESS/ERROR) and `word_t`.
- The FSM-state typedef stays local to the block.
- One sub-module is natural: `starve_counter`, a saturating counter with `inc`, `clr` and a `limit_hit` output.
- All other logic stays in the single module. Expected size is 150–250 lines.

## Test plan
- **Reset values.** Pulse `RST` mid-SERV_D → `dwait`=1, `ramWEN`=`ramREN`=0, `err`=0 immediately; next request starts from IDLE.
- **Single icache read.** `iREN`=1, `iaddr`=0x40, RAM returns ACCESS on the first SERV cycle with `ramload`=0x12345678 → cycle 1: `ramREN`=1, `ramaddr`=0x40, `iwait`=0, `iload`=0x12345678.
- **dcache block write vs contested icache.** dcache block write 0x100/0x104 with `iREN` held high → both dcache words complete consecutively with no IDLE cycle between them, and the icache is served after 0x104.
- **Starvation.** With the defaults, `iREN` held and dcache issuing back-to-back block reads → after the 4th dcache grant the icache is granted, and `starve` returns to 0.
- **RAM error.** Inject ERROR during a dcache read of 0x200 → `dwait`=0, `dload`=0xBAD1BAD1, `err`=1 and sticky, state returns to IDLE.
- **Withdrawal.** Drop `iREN` while the RAM reports BUSY → RAM strobes go to 0 that cycle, no `iwait` low pulse, state returns to IDLE.
